// File: rtl/spi_slave_sync.sv
// SPI slave oversampled on the system clock; all four CPOL/CPHA modes.
// Define SPI_SLAVE_SYNC_MISO_HIZ_EN to float miso while idle.
module spi_slave_sync #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  ss,
   input  logic                  mosi,
   output logic                  miso,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [2:0] sclk_sr;
   logic [2:0] ss_sr;
   logic [1:0] mosi_sr;

   logic sync_ok;
   logic ss_armed;
   logic cpol_q;
   logic cpha_q;
   logic miso_q;
   logic skip_shift;
   logic drv_first;

   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-1:0] rx_next;

   logic sclk_rise;
   logic sclk_fall;
   logic lead;
   logic trail;
   logic ss_fall;
   logic ss_rise;
   logic start;
   logic do_sample;
   logic do_drive;
   logic last;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sr <= 3'b000;
         ss_sr   <= 3'b111;
         mosi_sr <= 2'b00;
      end else begin
         sclk_sr <= {sclk_sr[1:0], sclk};
         ss_sr   <= {ss_sr[1:0], ss};
         mosi_sr <= {mosi_sr[0], mosi};
      end
   end

   // A frame may only start after ss has been seen high since reset,
   // so ss held low across reset cannot fake a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ok  <= 1'b0;
         ss_armed <= 1'b0;
      end else begin
         sync_ok <= 1'b1;
         if (sync_ok && ss_sr[0])
            ss_armed <= 1'b1;
      end
   end

   assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
   assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
   assign lead      = cpol_q ? sclk_fall : sclk_rise;
   assign trail     = cpol_q ? sclk_rise : sclk_fall;
   assign ss_fall   = ss_armed & ~ss_sr[1] & ss_sr[2];
   assign ss_rise   = ss_sr[1] & ~ss_sr[2];

   assign start     = (state == IDLE) & ss_fall;
   assign do_sample = (state == ACTIVE) & ~ss_rise
                    & (cpha_q ? trail : lead);
   assign do_drive  = (state == ACTIVE) & ~ss_rise
                    & (cpha_q ? lead : trail);
   assign last      = (bit_cnt == CW'(DATA_WIDTH - 1));
   assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_sr[1]};

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (ss_fall) state_nx = ACTIVE;
         ACTIVE: if (ss_rise) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         tx_shift   <= '0;
         rx_shift   <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         bit_cnt    <= '0;
         miso_q     <= 1'b0;
         skip_shift <= 1'b0;
         drv_first  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (start) begin
            cpol_q     <= cpol;
            cpha_q     <= cpha;
            tx_shift   <= tx_data;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            miso_q     <= tx_data[DATA_WIDTH-1];
            skip_shift <= 1'b0;
            drv_first  <= 1'b1;
         end else if (do_sample) begin
            if (last) begin
               rx_data  <= rx_next;
               rx_valid <= 1'b1;
               rx_shift <= '0;
               bit_cnt  <= '0;
               tx_shift <= tx_data;
               if (cpha_q) begin
                  drv_first <= 1'b1;
               end else begin
                  miso_q     <= tx_data[DATA_WIDTH-1];
                  skip_shift <= 1'b1;
               end
            end else begin
               rx_shift <= rx_next;
               bit_cnt  <= bit_cnt + 1'b1;
            end
         end else if (do_drive) begin
            if (cpha_q && drv_first) begin
               drv_first <= 1'b0;
               miso_q    <= tx_shift[DATA_WIDTH-1];
            end else if (!cpha_q && skip_shift) begin
               skip_shift <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
               miso_q   <= tx_shift[DATA_WIDTH-2];
            end
         end
      end
   end

   assign busy = (state == ACTIVE);

`ifdef SPI_SLAVE_SYNC_MISO_HIZ_EN
   assign miso = busy ? miso_q : 1'bz;
`else
   assign miso = busy ? miso_q : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: mode table, back-to-back,
// abort, mid-frame reset and idle miso level.
module tb_spi_slave_sync;

   localparam int W = 8;
   localparam int H = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         sclk;
   logic         ss;
   logic         mosi;
   logic         miso;
   logic         cpol;
   logic         cpha;
   logic [W-1:0] tx_data;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         busy;

   int n_chk = 0;
   int n_pass = 0;
   int n_pulse = 0;
   int n_push = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic         cpol;
      logic         cpha;
      logic [W-1:0] mtx;
      logic [W-1:0] stx;
      logic [W-1:0] exp_rx;
      logic [W-1:0] exp_mrx;
   } vec_t;

   vec_t tv[4];

   always #5 clk = ~clk;

   spi_slave_sync #(.DATA_WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .ss       (ss),
      .mosi     (mosi),
      .miso     (miso),
      .cpol     (cpol),
      .cpha     (cpha),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (rx_valid !== 1'b0) begin
         n_pulse++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL rx_unexpected: got %h want none", rx_data);
         end else begin
            chk("rx_word", rx_data, exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start(input logic cp, input logic ch,
                        input logic [W-1:0] tx);
      cpol    = cp;
      cpha    = ch;
      sclk    = cp;
      tx_data = tx;
      cyc(6);
      ss = 1'b0;
      cyc(H);
   endtask

   task automatic stop();
      ss = 1'b1;
      cyc(6);
   endtask

   task automatic bits(input logic [W-1:0] d, input int n,
                       input logic [W-1:0] tx_nxt,
                       output logic [W-1:0] r);
      r = '0;
      for (int i = 0; i < n; i++) begin
         if (!cpha) begin
            mosi = d[W-1-i];
            cyc(H);
            sclk = ~cpol;
            r = {r[W-2:0], miso};
            cyc(H);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = d[W-1-i];
            cyc(H);
            r = {r[W-2:0], miso};
            sclk = cpol;
            cyc(H);
         end
         if (i == 0) tx_data = tx_nxt;
      end
      if (!cpha) cyc(H);
   endtask

   task automatic push(input logic [W-1:0] v);
      exp_q.push_back(v);
      n_push++;
   endtask

   task automatic chk_idle_miso(input string nm);
`ifdef SPI_SLAVE_SYNC_MISO_HIZ_EN
      chk(nm, {7'b0, miso}, {7'b0, 1'bz});
`else
      chk(nm, {7'b0, miso}, 8'h00);
`endif
   endtask

   initial begin
      logic [W-1:0] r;
      logic [W-1:0] r2;

      tv[0] = '{1'b0, 1'b0, 8'hEA, 8'hCC, 8'hEA, 8'hCC};
      tv[1] = '{1'b1, 1'b1, 8'h88, 8'hC6, 8'h88, 8'hC6};
      tv[2] = '{1'b1, 1'b0, 8'h08, 8'h7E, 8'h08, 8'h7E};
      tv[3] = '{1'b0, 1'b1, 8'hFB, 8'h40, 8'hFB, 8'h40};

      rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
      cpol = 1'b0; cpha = 1'b0; tx_data = '0;
      cyc(3);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", {7'b0, rx_valid}, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk_idle_miso("rst_miso");
      rst = 1'b0;
      cyc(3);
      chk_idle_miso("idle_miso");

      // busy latency and miso driven at frame start
      tx_data = 8'h80;
      ss = 1'b0;
      cyc(2);
      chk("busy_rise_early", {7'b0, busy}, 8'h00);
      cyc(1);
      chk("busy_rise", {7'b0, busy}, 8'h01);
      chk("miso_active", {7'b0, miso}, 8'h01);
      ss = 1'b1;
      cyc(2);
      chk("busy_fall_early", {7'b0, busy}, 8'h01);
      cyc(1);
      chk("busy_fall", {7'b0, busy}, 8'h00);
      cyc(4);

      for (int k = 0; k < 4; k++) begin
         push(tv[k].exp_rx);
         start(tv[k].cpol, tv[k].cpha, tv[k].stx);
         bits(tv[k].mtx, W, tv[k].stx, r);
         stop();
         chk($sformatf("mrx_vec%0d", k), r, tv[k].exp_mrx);
         chk($sformatf("rx_data_vec%0d", k), rx_data, tv[k].exp_rx);
      end

      // back-to-back in mode 1, tx_data changes during frame 1
      push(8'h12);
      push(8'h34);
      start(1'b0, 1'b1, 8'h77);
      bits(8'h12, W, 8'h56, r);
      bits(8'h34, W, 8'h56, r2);
      stop();
      chk("b2b_mrx1", r, 8'h77);
      chk("b2b_mrx2", r2, 8'h56);
      chk("b2b_rx_data", rx_data, 8'h34);

      // abort after 5 bits
      start(1'b0, 1'b0, 8'h3A);
      bits(8'h5F, 5, 8'h3A, r);
      ss = 1'b1;
      cyc(3);
      chk("abort_busy", {7'b0, busy}, 8'h00);
      chk("abort_rx_hold", rx_data, 8'h34);
      cyc(3);
      push(8'hA5);
      start(1'b0, 1'b0, 8'h5A);
      bits(8'hA5, W, 8'h5A, r);
      stop();
      chk("post_abort_mrx", r, 8'h5A);
      chk("post_abort_rx", rx_data, 8'hA5);

      // reset mid-frame with ss held low
      start(1'b0, 1'b0, 8'hFF);
      bits(8'hC3, 3, 8'hFF, r);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("mrst_rx_data", rx_data, 8'h00);
      chk("mrst_busy", {7'b0, busy}, 8'h00);
      chk_idle_miso("mrst_miso");
      cyc(20);
      chk("mrst_no_start", {7'b0, busy}, 8'h00);
      ss = 1'b1;
      cyc(6);
      push(8'h3C);
      start(1'b0, 1'b0, 8'h99);
      bits(8'h3C, W, 8'h99, r);
      stop();
      chk("post_rst_mrx", r, 8'h99);
      chk("post_rst_rx", rx_data, 8'h3C);
      chk_idle_miso("final_idle_miso");

      cyc(4);
      chk("sb_empty", 8'(exp_q.size()), 8'h00);
      chk("pulse_count", 8'(n_pulse), 8'(n_push));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

System-clocked SPI slave: oversamples the master's `sclk`, `ss` and `mosi` into the `clk` domain and runs a full-duplex shift frame in all four CPOL/CPHA modes. It is the far end of the link driven by `spi_master`, used where the receiving logic must live on the system clock rather than on `sclk`. Received words come out as a one-cycle `rx_valid` strobe, and the transmit word is captured at frame start.

## Interface
- `DATA_WIDTH`, 8: bits per frame, MSB first.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: synchronous reset, active-high.
- `sclk` input 1: SPI clock from master, asynchronous to `clk`.
- `ss` input 1: slave select, active-low, asynchronous.
- `mosi` input 1: serial data from master, asynchronous.
- `miso` output 1: serial data to master.
- `cpol` input 1: clock polarity, captured at frame start.
- `cpha` input 1: clock phase, captured at frame start.
- `tx_data` input DATA_WIDTH: word to send, captured at frame start.
- `rx_data` output DATA_WIDTH: last complete received word.
- `rx_valid` output 1: one-cycle pulse, `rx_data` updated this cycle.
- `busy` output 1: high while a frame is in progress (state ACTIVE).

## Operation
- Each of `sclk`, `ss` and `mosi` passes through a 2-flop synchronizer. A third flop on `sclk` and on `ss` gives edge detection.
- Synchronizer reset values: `sclk` 0, `ss` 1, `mosi` 0.
- FSM states:
  - IDLE → ACTIVE on synchronized `ss` falling edge.
  - ACTIVE → IDLE on synchronized `ss` rising edge.
- On the IDLE→ACTIVE transition:
  - latch `cpol`, `cpha` and `tx_data` into `mode_q` and `tx_shift`;
  - clear `bit_cnt` and `rx_shift`;
  - drive `miso` = `tx_data[DATA_WIDTH-1]`.
- Edge naming: leading edge is `sclk` rising if `cpol_q`=0, falling if `cpol_q`=1. Trailing edge is the opposite.
- `cpha_q`=0:
  - sample `mosi` on the leading edge;
  - shift `tx_shift` left and drive the next MSB on the trailing edge.
- `cpha_q`=1:
  - shift and drive on the leading edge (the first leading edge drives bit DATA_WIDTH-1);
  - sample on the trailing edge.
- Sampling: `rx_shift` ← {`rx_shift`[DATA_WIDTH-2:0], `mosi_sync`}, and `bit_cnt` increments.
- On the DATA_WIDTH-th sample:
  - `rx_data` ← assembled word, `rx_valid`=1 for one cycle;
  - `bit_cnt` wraps to 0;
  - `tx_shift` reloads from the current `tx_data`, and `miso` presents its MSB when `cpha_q`=0.
  - This gives back-to-back frames with `ss` held low. `cpol`/`cpha` are not re-latched.
- When `cpha_q`=0, the trailing edge after the final sample does not shift. The reloaded MSB stays on `miso`.
- `ss` rising edge mid-frame (`bit_cnt`≠0): abort, no `rx_valid`, `rx_data` unchanged, return to IDLE.
- `sclk` edges in IDLE are ignored. This covers the spurious edge from synchronizer reset when `cpol`=1.
- A sample and an `ss` rising edge detected in the same cycle: the `ss` edge wins, and the sample is discarded.
- `rst` mid-frame: all state cleared to IDLE. A new frame requires a fresh `ss` falling edge; `ss` still low when `rst` drops does not start a frame.

## Timing
- Reset values: `miso`=0 (Hi-Z under the macro), `rx_data`=0, `rx_valid`=0, `busy`=0, state IDLE.
- Pin-to-action latency: 3 `clk` cycles from an `sclk`/`ss` pin edge to the cycle the action is registered.
- `miso` changes 3 `clk` cycles after the shifting `sclk` edge.
- `rx_valid` asserts 3 cycles after the final sampling `sclk` edge.
- `busy` rises 3 cycles after `ss` falls and drops 3 cycles after `ss` rises.
- Required ratios: `sclk` high and low phases each ≥ 4 `clk` periods. `ss` falling to first `sclk` edge ≥ 4 `clk` periods.
- `tx_data` must be stable from `ss` assertion until the 4th `clk` after it, and around each frame boundary.
- `cpol`/`cpha` must be stable before `ss` falls.

## Configuration
- `SPI_SLAVE_SYNC_MISO_HIZ_EN`:
  - Defined: `miso` = 1'bz whenever state is IDLE, including during and after reset. The shared bus carries multiple slaves.
  - Undefined: `miso` is driven 0 in IDLE.
- The macro has no effect in ACTIVE.

## Test plan
- Mode 0 (`cpol`=0, `cpha`=0), master sends 0xEA, `tx_data`=0xCC → `rx_data`=0xEA with a single `rx_valid` pulse; master receives 0xCC.
- Mode 3, master 0x88, `tx_data`=0xC6 → `rx_data`=0x88; master receives 0xC6. Mode 2, 0x08/0x7E → 0x08 and 0x7E.
- Mode 1, master 0xFB, `tx_data`=0x40 → `rx_data`=0xFB; master receives 0x40. Then two back-to-back frames with `ss` low (0x12, then 0x34; `tx_data` changed to 0x56 between them) → two `rx_valid` pulses with 0x12 and 0x34; master receives 0x56 in frame 2.
- `ss` deasserted after 5 bits → no `rx_valid`, `rx_data` holds its previous value, `busy`=0 three cycles after `ss` rises. The next full frame of 0xA5 is received correctly.
- `rst` pulsed mid-frame with `ss` held low → outputs at reset values. No frame starts until `ss` goes high then low; the following 0x3C frame is received correctly.
- With `SPI_SLAVE_SYNC_MISO_HIZ_EN` defined → `miso`=z in reset and IDLE, and driven during ACTIVE. Without the macro → `miso`=0 in IDLE.
